// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel between NUM_CONSUMERS requesters.
// Define MEM_ARB_TIMEOUT_EN to enable the wait-cycle timeout and sticky timeout_err flag.
module mem_rr_arbiter #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,

    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,

    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,

    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready,

    output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int ID_W = $clog2(NUM_CONSUMERS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CONSUMERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                             state_q, state_d;
    logic [ID_W-1:0]                    ptr_q, ptr_d;
    logic [ID_W-1:0]                    grant_q, grant_d;
    logic                               mem_rd_valid_q, mem_rd_valid_d;
    logic                               mem_wr_valid_q, mem_wr_valid_d;
    logic [ADDR_BITS-1:0]               addr_q, addr_d;
    logic [DATA_BITS-1:0]               wdata_q, wdata_d;
    logic [NUM_CONSUMERS-1:0]           rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]           wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                               timeout_err_q, timeout_err_d;

    logic [NUM_CONSUMERS-1:0]           wr_req;
    logic                               scan_found;
    logic                               scan_is_write;
    logic [ID_W-1:0]                    scan_id;
    logic                               wait_expired;

    // A read-only port never sees write requests, so they cannot win a grant.
    assign wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Scan starts one past the last winner and wraps, so every requester is reached within N grants.
    always_comb begin
        int              slot;
        logic [ID_W-1:0] slot_id;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        scan_found    = 1'b0;
        scan_is_write = 1'b0;
        scan_id       = '0;
        slot          = 0;
        slot_id       = '0;
        for (int off = 1; off <= NUM_CONSUMERS; off++) begin
            slot = int'(ptr_q) + off;
            if (slot >= NUM_CONSUMERS) begin
                slot = slot - NUM_CONSUMERS;
            end
            slot_id = ID_W'(slot);
            if (!scan_found && (consumer_read_valid[slot_id] || wr_req[slot_id])) begin
                scan_found    = 1'b1;
                scan_id       = slot_id;
                scan_is_write = !consumer_read_valid[slot_id];
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;

    // Expiry fires on the last of TIMEOUT_CYCLES wait cycles, so mem valid is high exactly that long.
    assign wait_expired = (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == IDLE) begin
            wait_cnt_d = '0;
        end else if ((state_q == READ_WAITING || state_q == WRITE_WAITING) && !wait_expired) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        mem_rd_valid_d = mem_rd_valid_q;
        mem_wr_valid_d = mem_wr_valid_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_ready_d     = rd_ready_q;
        wr_ready_d     = wr_ready_q;
        rd_data_d      = rd_data_q;
        timeout_err_d  = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    ptr_d   = scan_id;
                    grant_d = scan_id;
                    if (scan_is_write) begin
                        state_d        = WRITE_WAITING;
                        mem_wr_valid_d = 1'b1;
                        addr_d         = consumer_write_address[int'(scan_id)*ADDR_BITS +: ADDR_BITS];
                        wdata_d        = consumer_write_data[int'(scan_id)*DATA_BITS +: DATA_BITS];
                    end else begin
                        state_d        = READ_WAITING;
                        mem_rd_valid_d = 1'b1;
                        addr_d         = consumer_read_address[int'(scan_id)*ADDR_BITS +: ADDR_BITS];
                    end
                end
            end

            READ_WAITING: begin
                if (mem_read_ready) begin
                    state_d                                        = READ_RELAYING;
                    mem_rd_valid_d                                 = 1'b0;
                    rd_ready_d[grant_q]                            = 1'b1;
                    rd_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
                end else if (wait_expired) begin
                    state_d                                        = READ_RELAYING;
                    mem_rd_valid_d                                 = 1'b0;
                    rd_ready_d[grant_q]                            = 1'b1;
                    rd_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = '1;
                    timeout_err_d                                  = 1'b1;
                end
            end

            WRITE_WAITING: begin
                if (mem_write_ready || wait_expired) begin
                    state_d             = WRITE_RELAYING;
                    mem_wr_valid_d      = 1'b0;
                    wr_ready_d[grant_q] = 1'b1;
                    if (!mem_write_ready) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end

            READ_RELAYING: begin
                if (!consumer_read_valid[grant_q]) begin
                    state_d             = IDLE;
                    rd_ready_d[grant_q] = 1'b0;
                end
            end

            WRITE_RELAYING: begin
                if (!consumer_write_valid[grant_q]) begin
                    state_d             = IDLE;
                    wr_ready_d[grant_q] = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= LAST_ID;
            grant_q        <= '0;
            mem_rd_valid_q <= 1'b0;
            mem_wr_valid_q <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_ready_q     <= '0;
            wr_ready_q     <= '0;
            // NOTE: the per-consumer read data registers are reset too, because they drive outputs directly.
            rd_data_q      <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rd_ready_q     <= rd_ready_d;
            wr_ready_q     <= wr_ready_d;
            rd_data_q      <= rd_data_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign mem_read_valid       = mem_rd_valid_q;
    assign mem_read_address     = addr_q;

    assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q     : '0;
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wr_valid_q : 1'b0;
    assign mem_write_address    = (WRITE_ENABLE != 0) ? addr_q         : '0;
    assign mem_write_data       = (WRITE_ENABLE != 0) ? wdata_q        : '0;

    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: directed stimulus pushes expected memory requests and
// consumer responses into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_rr_arbiter;

    localparam int N       = 4;
    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    id;
    } mem_exp_t;

    typedef struct {
        logic          is_write;
        logic [1:0]    id;
        logic [DW-1:0] data;
    } rsp_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    c_rv, c_wv;
    logic [N*AW-1:0] c_ra, c_wa;
    logic [N*DW-1:0] c_wd;
    logic [N-1:0]    consumer_read_ready, consumer_write_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid, mem_write_valid;
    logic [AW-1:0]   mem_read_address, mem_write_address;
    logic [DW-1:0]   mem_write_data;
    logic            m_rr, m_wr;
    logic [DW-1:0]   m_rd;
    logic [1:0]      grant_id;
    logic            busy, timeout_err;

    logic [N-1:0]    ro_wv;
    logic [N-1:0]    ro_crr, ro_cwr;
    logic [N*DW-1:0] ro_crd;
    logic            ro_mrv, ro_mwv;
    logic [AW-1:0]   ro_mra, ro_mwa;
    logic [DW-1:0]   ro_mwd;
    logic [1:0]      ro_gid;
    logic            ro_busy, ro_tmo;

    mem_rr_arbiter #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N),
        .WRITE_ENABLE(1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(m_rr), .mem_read_data(m_rd),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(m_wr),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    mem_rr_arbiter #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)
    ) dut_ro (
        .clk(clk), .reset(rst_n),
        .consumer_read_valid('0), .consumer_read_address('0),
        .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
        .consumer_write_valid(ro_wv), .consumer_write_address({N{8'h5A}}),
        .consumer_write_data({N{16'hC0DE}}), .consumer_write_ready(ro_cwr),
        .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
        .mem_read_ready(1'b1), .mem_read_data(16'h0F0F),
        .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
        .mem_write_data(ro_mwd), .mem_write_ready(1'b1),
        .grant_id(ro_gid), .busy(ro_busy), .timeout_err(ro_tmo)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    function automatic void exp_mem(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [1:0] id);
        mem_exp_t e;
        e.is_write = w; e.addr = a; e.data = d; e.id = id;
        mem_q.push_back(e);
    endfunction

    function automatic void exp_rsp(input logic w, input logic [1:0] id, input logic [DW-1:0] d);
        rsp_exp_t e;
        e.is_write = w; e.id = id; e.data = d;
        rsp_q.push_back(e);
    endfunction

    // Monitor: compares each new memory request and each new consumer ready pulse.
    logic         prev_mrv, prev_mwv;
    logic [N-1:0] prev_crr, prev_cwr;
    int           mrv_cycles = 0;

    always @(negedge clk) begin
        mem_exp_t me;
        rsp_exp_t re;
        if (!rst_n) begin
            prev_mrv <= 1'b0;
            prev_mwv <= 1'b0;
            prev_crr <= '0;
            prev_cwr <= '0;
        end else begin
            if (mem_read_valid) mrv_cycles <= mrv_cycles + 1;
            if (mem_read_valid && !prev_mrv) begin
                if (mem_q.size() == 0) check("mem_rd_unexpected", 32'(mem_q.size()), 1);
                else begin
                    me = mem_q.pop_front();
                    check("mem_rd_kind", 32'(me.is_write), 0);
                    check("mem_rd_addr", 32'(mem_read_address), 32'(me.addr));
                    check("mem_rd_grant", 32'(grant_id), 32'(me.id));
                end
            end
            if (mem_write_valid && !prev_mwv) begin
                if (mem_q.size() == 0) check("mem_wr_unexpected", 32'(mem_q.size()), 1);
                else begin
                    me = mem_q.pop_front();
                    check("mem_wr_kind", 32'(me.is_write), 1);
                    check("mem_wr_addr", 32'(mem_write_address), 32'(me.addr));
                    check("mem_wr_data", 32'(mem_write_data), 32'(me.data));
                    check("mem_wr_grant", 32'(grant_id), 32'(me.id));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i] && !prev_crr[i]) begin
                    if (rsp_q.size() == 0) check("rsp_rd_unexpected", 32'(rsp_q.size()), 1);
                    else begin
                        re = rsp_q.pop_front();
                        check("rsp_rd_kind", 32'(re.is_write), 0);
                        check("rsp_rd_id", 32'(i), 32'(re.id));
                        check("rsp_rd_data", 32'(consumer_read_data[i*DW +: DW]), 32'(re.data));
                    end
                end
                if (consumer_write_ready[i] && !prev_cwr[i]) begin
                    if (rsp_q.size() == 0) check("rsp_wr_unexpected", 32'(rsp_q.size()), 1);
                    else begin
                        re = rsp_q.pop_front();
                        check("rsp_wr_kind", 32'(re.is_write), 1);
                        check("rsp_wr_id", 32'(i), 32'(re.id));
                    end
                end
            end
            prev_mrv <= mem_read_valid;
            prev_mwv <= mem_write_valid;
            prev_crr <= consumer_read_ready;
            prev_cwr <= consumer_write_ready;
        end
    end

    // Memory model: answers after MEM_LAT extra cycles while enabled.
    logic mem_en;

    initial begin
        logic [DW-1:0] mem_arr [256];
        int rd_wait, wr_wait;
        for (int a = 0; a < 256; a++) mem_arr[a] = '0;
        mem_arr[8'h3C] = 16'hBEEF;
        for (int i = 0; i < N; i++) mem_arr[8'h20 + i] = 16'hA000 + 16'(i);
        m_rr = 1'b0; m_wr = 1'b0; m_rd = '0;
        rd_wait = 0; wr_wait = 0;
        forever begin
            @(posedge clk); #1;
            m_rr = 1'b0;
            m_wr = 1'b0;
            if (!mem_en || !mem_read_valid) rd_wait = 0;
            else if (rd_wait >= MEM_LAT) begin
                m_rr = 1'b1; m_rd = mem_arr[mem_read_address]; rd_wait = 0;
            end else rd_wait++;
            if (!mem_en || !mem_write_valid) wr_wait = 0;
            else if (wr_wait >= MEM_LAT) begin
                m_wr = 1'b1; mem_arr[mem_write_address] = mem_write_data; wr_wait = 0;
            end else wr_wait++;
        end
    end

    // Consumers: raise requests as counted, drop valid on ready, stop when everything is idle.
    int rd_left[N];
    int wr_left[N];

    task automatic run_batch(input string name, input int max_cycles);
        bit done = 1'b0;
        int pending;
        for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
            @(posedge clk); #1;
            pending = 0;
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i]) c_rv[i] = 1'b0;
                else if (!c_rv[i] && rd_left[i] > 0) begin c_rv[i] = 1'b1; rd_left[i]--; end
                if (consumer_write_ready[i]) c_wv[i] = 1'b0;
                else if (!c_wv[i] && wr_left[i] > 0) begin c_wv[i] = 1'b1; wr_left[i]--; end
                pending += rd_left[i] + wr_left[i];
            end
            done = (pending == 0) && (c_rv == '0) && (c_wv == '0) && !busy &&
                   (consumer_read_ready == '0) && (consumer_write_ready == '0);
        end
        check({name, "_done"}, 32'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0; ro_wv = '0;
        mem_en = 1'b1;
        for (int i = 0; i < N; i++) begin rd_left[i] = 0; wr_left[i] = 0; end

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_mem_rd_valid", 32'(mem_read_valid), 0);
        check("rst_mem_wr_valid", 32'(mem_write_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_rd_ready", 32'(consumer_read_ready), 0);
        check("rst_wr_ready", 32'(consumer_write_ready), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Round-robin: all four request together, consumer 0 re-requests once served
        for (int i = 0; i < N; i++) c_ra[i*AW +: AW] = 8'h20 + 8'(i);
        rd_left[0] = 2; rd_left[1] = 1; rd_left[2] = 1; rd_left[3] = 1;
        for (int i = 0; i < N; i++) begin
            exp_mem(1'b0, 8'h20 + 8'(i), '0, 2'(i));
            exp_rsp(1'b0, 2'(i), 16'hA000 + 16'(i));
        end
        exp_mem(1'b0, 8'h20, '0, 2'd0);
        exp_rsp(1'b0, 2'd0, 16'hA000);
        run_batch("rr", 200);

        // Write then read: pointer sits at 0, so consumer 1 (write) precedes consumer 3 (read)
        c_wa[1*AW +: AW] = 8'h10;
        c_wd[1*DW +: DW] = 16'h1234;
        c_ra[3*AW +: AW] = 8'h10;
        wr_left[1] = 1; rd_left[3] = 1;
        exp_mem(1'b1, 8'h10, 16'h1234, 2'd1);
        exp_mem(1'b0, 8'h10, '0, 2'd3);
        exp_rsp(1'b1, 2'd1, '0);
        exp_rsp(1'b0, 2'd3, 16'h1234);
        run_batch("wr_rd", 100);

        // Single read by consumer 2 with timing checks and an address change after grant
        @(posedge clk); #1;
        c_ra[2*AW +: AW] = 8'h3C;
        c_rv[2] = 1'b1;
        exp_mem(1'b0, 8'h3C, '0, 2'd2);
        exp_rsp(1'b0, 2'd2, 16'hBEEF);
        @(negedge clk);
        check("rd1_valid_before_edge", 32'(mem_read_valid), 0);
        @(posedge clk); #1;
        c_ra[2*AW +: AW] = 8'h55;
        @(negedge clk);
        check("rd1_valid_latency", 32'(mem_read_valid), 1);
        check("rd1_addr", 32'(mem_read_address), 32'h3C);
        check("rd1_grant", 32'(grant_id), 2);
        check("rd1_busy", 32'(busy), 1);
        @(negedge clk);
        check("rd1_addr_latched", 32'(mem_read_address), 32'h3C);
        for (int k = 0; k < 20 && !consumer_read_ready[2]; k++) @(negedge clk);
        check("rd1_ready", 32'(consumer_read_ready[2]), 1);
        check("rd1_data", 32'(consumer_read_data[2*DW +: DW]), 32'hBEEF);
        check("rd1_mem_valid_dropped", 32'(mem_read_valid), 0);
        check("rd1_others_ready", 32'(consumer_read_ready & 4'b1011), 0);
        @(posedge clk); #1;
        check("rd1_ready_held", 32'(consumer_read_ready[2]), 1);
        c_rv[2] = 1'b0;
        @(negedge clk);
        check("rd1_ready_until_edge", 32'(consumer_read_ready[2]), 1);
        @(negedge clk);
        check("rd1_ready_dropped", 32'(consumer_read_ready[2]), 0);
        check("rd1_data_kept", 32'(consumer_read_data[2*DW +: DW]), 32'hBEEF);
        check("rd1_idle", 32'(busy), 0);

        // Async reset during READ_WAITING (pointer at 2, consumer 1 is the only requester)
        mem_en = 1'b0;
        @(posedge clk); #1;
        c_ra[1*AW +: AW] = 8'h44;
        c_rv[1] = 1'b1;
        exp_mem(1'b0, 8'h44, '0, 2'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("arst_pre_busy", 32'(busy), 1);
        check("arst_pre_valid", 32'(mem_read_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_valid", 32'(mem_read_valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_grant", 32'(grant_id), 0);
        check("arst_rd_ready", 32'(consumer_read_ready), 0);
        check("arst_rd_data_lo", consumer_read_data[31:0], 0);
        check("arst_rd_data_hi", consumer_read_data[63:32], 0);
        c_rv = '0;
        mem_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // After reset consumer 0 has first priority over consumer 3
        rd_left[0] = 1; rd_left[3] = 1;
        exp_mem(1'b0, 8'h20, '0, 2'd0);
        exp_mem(1'b0, 8'h10, '0, 2'd3);
        exp_rsp(1'b0, 2'd0, 16'hA000);
        exp_rsp(1'b0, 2'd3, 16'h1234);
        run_batch("post_rst", 100);

`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int snap;
            mem_en = 1'b0;
            snap = mrv_cycles;
            c_ra[1*AW +: AW] = 8'h44;
            rd_left[1] = 1;
            exp_mem(1'b0, 8'h44, '0, 2'd1);
            exp_rsp(1'b0, 2'd1, 16'hFFFF);
            run_batch("tmo", 100);
            check("tmo_valid_cycles", 32'(mrv_cycles - snap), 8);
            check("tmo_flag", 32'(timeout_err), 1);
            repeat (3) @(negedge clk);
            check("tmo_flag_sticky", 32'(timeout_err), 1);
            mem_en = 1'b1;
        end
`else
        check("no_tmo_flag", 32'(timeout_err), 0);
`endif

        // Read-only instance: held write request is ignored entirely
        @(posedge clk); #1;
        ro_wv[0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("ro_mem_wr_valid", 32'(ro_mwv), 0);
            check("ro_busy", 32'(ro_busy), 0);
            check("ro_wr_ready", 32'(ro_cwr), 0);
        end
        ro_wv = '0;

        repeat (4) @(negedge clk);
        check("mem_q_drained", 32'(mem_q.size()), 0);
        check("rsp_q_drained", 32'(rsp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
